// File: rtl/disc_flipper.sv
// rtl/disc_flipper.sv - commits a validated move to board RAM and flips captured discs
// Optional feature macro: DISC_FLIPPER_ERR_EN (adds sticky err output for abnormal walks)
module disc_flipper #(
    parameter int MAX_WALK = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] s_addr_in,
    input  logic       player,
    input  logic [7:0] dir_mask,
    input  logic [1:0] data_in,
    output logic [6:0] addr_out,
    output logic       wren_o,
    output logic [1:0] data_out,
    output logic       busy,
    output logic       done,
    output logic [5:0] flip_count
`ifdef DISC_FLIPPER_ERR_EN
    ,
    output logic       err
`endif
);
    localparam int WW = $clog2(MAX_WALK + 1);
    localparam logic [WW-1:0] WALK_LIMIT = WW'(MAX_WALK);

    typedef enum logic [2:0] {IDLE, PLACE, SCAN, RD, CHK, WR, DONE} state_t;
    state_t state, state_nxt;

    logic [6:0]    origin;
    logic [6:0]    cur;
    logic [6:0]    rd_addr;
    logic [1:0]    own;
    logic [1:0]    opp;
    logic [7:0]    mask;
    logic [2:0]    dir_idx;
    logic [WW-1:0] walk;
    logic          last_dir;
    logic          can_flip;

    // Step offsets on the 10x10 padded board, encoded modulo 128.
    function automatic logic [6:0] step_of(input logic [2:0] d);
        case (d)
            3'd0:    step_of = 7'd117;
            3'd1:    step_of = 7'd118;
            3'd2:    step_of = 7'd119;
            3'd3:    step_of = 7'd127;
            3'd4:    step_of = 7'd1;
            3'd5:    step_of = 7'd9;
            3'd6:    step_of = 7'd10;
            default: step_of = 7'd11;
        endcase
    endfunction

    assign opp      = ~own;
    assign rd_addr  = cur + step_of(dir_idx);
    assign last_dir = (dir_idx == 3'd7);
    assign can_flip = (data_in == opp) && (walk < WALK_LIMIT);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_out  = 7'd0;
        wren_o    = 1'b0;
        data_out  = 2'b00;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PLACE;
            end
            PLACE: begin
                addr_out  = origin;
                wren_o    = 1'b1;
                data_out  = own;
                state_nxt = SCAN;
            end
            SCAN: begin
                if (mask[dir_idx])  state_nxt = RD;
                else if (last_dir)  state_nxt = DONE;
            end
            RD: begin
                addr_out  = rd_addr;
                state_nxt = CHK;
            end
            CHK: begin
                if (can_flip)      state_nxt = WR;
                else if (last_dir) state_nxt = DONE;
                else               state_nxt = SCAN;
            end
            WR: begin
                addr_out  = cur;
                wren_o    = 1'b1;
                data_out  = own;
                state_nxt = RD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            origin     <= 7'd0;
            own        <= 2'b00;
            mask       <= 8'd0;
            dir_idx    <= 3'd0;
            cur        <= 7'd0;
            walk       <= '0;
            flip_count <= 6'd0;
`ifdef DISC_FLIPPER_ERR_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        origin     <= s_addr_in;
                        own        <= player ? 2'b10 : 2'b01;
                        mask       <= dir_mask;
                        dir_idx    <= 3'd0;
                        flip_count <= 6'd0;
`ifdef DISC_FLIPPER_ERR_EN
                        err        <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (mask[dir_idx]) begin
                        cur  <= origin;
                        walk <= '0;
                    end else if (!last_dir) begin
                        dir_idx <= dir_idx + 3'd1;
                    end
                end
                RD: begin
                    cur  <= rd_addr;
                    walk <= walk + 1'b1;
                end
                CHK: begin
                    if (!can_flip) begin
                        if (!last_dir) dir_idx <= dir_idx + 3'd1;
`ifdef DISC_FLIPPER_ERR_EN
                        // Anything but the own disc ends the walk abnormally.
                        if (data_in != own) err <= 1'b1;
`endif
                    end
                end
                WR: begin
                    if (flip_count != 6'd63) flip_count <= flip_count + 6'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_disc_flipper.sv
// tb/tb_disc_flipper.sv - table-driven self-checking bench for disc_flipper
module tb_disc_flipper;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] s_addr_in = 7'd0;
    logic       player = 1'b0;
    logic [7:0] dir_mask = 8'd0;
    logic [1:0] data_in;
    logic [6:0] addr_out;
    logic       wren_o;
    logic [1:0] data_out;
    logic       busy;
    logic       done;
    logic [5:0] flip_count;
`ifdef DISC_FLIPPER_ERR_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;

    logic [1:0] ram [128];
    logic [1:0] pre_ram [128];
    logic       init_req = 1'b0;
    int         wr_cnt = 0;

    typedef struct {
        logic [6:0]      origin;
        logic            ply;
        logic [7:0]      mask;
        int              np;
        logic [7:0][6:0] pa;
        logic [7:0][1:0] pv;
        int              ne;
        logic [7:0][6:0] ea;
        logic [7:0][1:0] ev;
        int              flips;
        int              cycles;
        int              writes;
        logic            e_err;
    } vec_t;

    vec_t vec [7];

    disc_flipper #(.MAX_WALK(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .s_addr_in  (s_addr_in),
        .player     (player),
        .dir_mask   (dir_mask),
        .data_in    (data_in),
        .addr_out   (addr_out),
        .wren_o     (wren_o),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .flip_count (flip_count)
`ifdef DISC_FLIPPER_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        data_in <= ram[addr_out];
        if (init_req) begin
            for (int i = 0; i < 128; i++) ram[i] <= pre_ram[i];
        end else if (wren_o) begin
            ram[addr_out] <= data_out;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int v, input int o, input logic p, input logic [7:0] m,
                        input int fl, input int cy, input int wr, input logic e);
        vec[v].origin = 7'(o);
        vec[v].ply    = p;
        vec[v].mask   = m;
        vec[v].np     = 0;
        vec[v].ne     = 0;
        vec[v].pa     = '0;
        vec[v].pv     = '0;
        vec[v].ea     = '0;
        vec[v].ev     = '0;
        vec[v].flips  = fl;
        vec[v].cycles = cy;
        vec[v].writes = wr;
        vec[v].e_err  = e;
    endtask

    task automatic pre(input int v, input int a, input logic [1:0] d);
        vec[v].pa[vec[v].np] = 7'(a);
        vec[v].pv[vec[v].np] = d;
        vec[v].np++;
    endtask

    task automatic ex(input int v, input int a, input logic [1:0] d);
        vec[v].ea[vec[v].ne] = 7'(a);
        vec[v].ev[vec[v].ne] = d;
        vec[v].ne++;
    endtask

    task automatic load_board(input int v);
        for (int i = 0; i < 128; i++) begin
            pre_ram[i] = (i >= 90 || i < 10 || i % 10 == 0 || i % 10 == 9) ? 2'b11 : 2'b00;
        end
        for (int k = 0; k < vec[v].np; k++) pre_ram[vec[v].pa[k]] = vec[v].pv[k];
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
    endtask

    task automatic launch(input int v);
        s_addr_in = vec[v].origin;
        player    = vec[v].ply;
        dir_mask  = vec[v].mask;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic run_move(input int v, input int ignore_at);
        int cyc;
        int base;
        load_board(v);
        base = wr_cnt;
        launch(v);
        cyc = 1;
        chk($sformatf("v%0d busy_first", v), int'(busy), 1);
        while (!done && cyc < 200) begin
            start = (cyc == ignore_at);
            if (cyc == ignore_at) begin
                s_addr_in = 7'd55;
                dir_mask  = 8'h00;
                player    = ~vec[v].ply;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("v%0d done_cycle", v), cyc, vec[v].cycles);
        chk($sformatf("v%0d flip_count", v), int'(flip_count), vec[v].flips);
        chk($sformatf("v%0d writes", v), wr_cnt - base, vec[v].writes);
`ifdef DISC_FLIPPER_ERR_EN
        chk($sformatf("v%0d err", v), int'(err), int'(vec[v].e_err));
`endif
        for (int k = 0; k < vec[v].ne; k++) begin
            chk($sformatf("v%0d ram[%0d]", v, vec[v].ea[k]), int'(ram[vec[v].ea[k]]),
                int'(vec[v].ev[k]));
        end
        @(negedge clock);
        chk($sformatf("v%0d idle_busy", v), int'(busy), 0);
        chk($sformatf("v%0d idle_done", v), int'(done), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " addr_out"}, int'(addr_out), 0);
        chk({tag, " wren_o"}, int'(wren_o), 0);
        chk({tag, " data_out"}, int'(data_out), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " flip_count"}, int'(flip_count), 0);
`ifdef DISC_FLIPPER_ERR_EN
        chk({tag, " err"}, int'(err), 0);
`endif
    endtask

    initial begin
        int n;
        setv(0, 44, 1'b0, 8'h10, 1, 15, 2, 1'b0);
        pre(0, 45, 2'b10); pre(0, 46, 2'b01);
        ex(0, 44, 2'b01); ex(0, 45, 2'b01); ex(0, 46, 2'b01); ex(0, 55, 2'b00);

        setv(1, 55, 1'b1, 8'h00, 0, 10, 1, 1'b0);
        ex(1, 55, 2'b10); ex(1, 44, 2'b00);

        setv(2, 44, 1'b1, 8'h18, 4, 26, 5, 1'b0);
        pre(2, 43, 2'b01); pre(2, 42, 2'b10);
        pre(2, 45, 2'b01); pre(2, 46, 2'b01); pre(2, 47, 2'b01); pre(2, 48, 2'b10);
        ex(2, 44, 2'b10); ex(2, 43, 2'b10); ex(2, 42, 2'b10);
        ex(2, 45, 2'b10); ex(2, 46, 2'b10); ex(2, 47, 2'b10);

        setv(3, 44, 1'b1, 8'h10, 1, 15, 2, 1'b1);
        pre(3, 45, 2'b01);
        ex(3, 44, 2'b10); ex(3, 45, 2'b10); ex(3, 46, 2'b00);

        setv(4, 11, 1'b0, 8'h01, 0, 12, 1, 1'b1);
        ex(4, 11, 2'b01); ex(4, 0, 2'b11);

        setv(5, 55, 1'b0, 8'h81, 3, 23, 4, 1'b0);
        pre(5, 44, 2'b10); pre(5, 33, 2'b01); pre(5, 66, 2'b10); pre(5, 77, 2'b10);
        pre(5, 88, 2'b01);
        ex(5, 55, 2'b01); ex(5, 44, 2'b01); ex(5, 66, 2'b01); ex(5, 77, 2'b01);
        ex(5, 33, 2'b01);

        // Walk limit of 4 stops the fourth opponent disc from being flipped.
        setv(6, 41, 1'b0, 8'h10, 3, 21, 4, 1'b1);
        pre(6, 42, 2'b10); pre(6, 43, 2'b10); pre(6, 44, 2'b10); pre(6, 45, 2'b10);
        pre(6, 46, 2'b01);
        ex(6, 41, 2'b01); ex(6, 42, 2'b01); ex(6, 43, 2'b01); ex(6, 44, 2'b01);
        ex(6, 45, 2'b10);

        @(negedge clock);
        @(negedge clock);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 7; v++) run_move(v, 0);

        // start while busy must be ignored
        run_move(0, 3);

        // asynchronous reset during the second WR of move 2
        load_board(2);
        launch(2);
        n = 0;
        while (!(wren_o && addr_out == 7'd45) && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("reset_wr_reached", int'(n < 60), 1);
        chk("reset_wr_flip_count", int'(flip_count), 1);
        reset = 1'b0;
        #1;
        chk_zero("midwalk_reset");
        @(negedge clock);
        chk("reset_kept_ram43", int'(ram[43]), 2);
        reset = 1'b1;
        @(negedge clock);
        run_move(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
